// File: rtl/seq_pkg.sv
// Shared constants for the instruction sequencer: step encodings and opcodes.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'b000,
        ST_WAIT  = 3'b001,
        ST_DEC   = 3'b010,
        ST_EX1   = 3'b011,
        ST_EX2   = 3'b100,
        ST_EX3   = 3'b101
    } step_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MV  = 3'b110;
    localparam logic [2:0] OP_MVI = 3'b111;

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to one-hot 8-bit register select.
module dec3to8 (
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    assign onehot = 8'b1 << sel;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/step sequencer feeding the control unit: owns PC, IR and the step counter.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic              Done,
    input  logic              Clear,
    input  logic [DATA_W-1:0] MemData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] DIN,
    output logic [2:0]        Counter,
    output logic [2:0]        IRout,
    output logic [7:0]        Xreg,
    output logic [7:0]        Yreg,
    output logic              Busy,
    output logic              Err
);

    step_t             step, step_nxt;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic              ir_ld, pc_inc, err_nxt;

    always_comb begin
        step_nxt = step;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        err_nxt  = 1'b0;
        case (step)
            ST_FETCH: if (Run) step_nxt = ST_WAIT;
            ST_WAIT: begin
                step_nxt = ST_DEC;
                ir_ld    = 1'b1;
                pc_inc   = 1'b1;
            end
            ST_DEC:   step_nxt = ST_EX1;
            ST_EX1: begin
                step_nxt = Done ? ST_FETCH : ST_EX2;
                // step past the immediate word so the next fetch lands on an opcode
                pc_inc   = (ir[DATA_W-1 -: 3] == OP_MVI);
            end
            ST_EX2:   step_nxt = Done ? ST_FETCH : ST_EX3;
            ST_EX3: begin
                step_nxt = ST_FETCH;
                err_nxt  = !Done;
            end
            default:  step_nxt = ST_FETCH;
        endcase
        // abort wins over everything, including a simultaneous Done
        if (Clear) begin
            step_nxt = ST_FETCH;
            ir_ld    = 1'b0;
            pc_inc   = 1'b0;
            err_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            step <= ST_FETCH;
            ir   <= '0;
            pc   <= RESET_PC;
            Err  <= 1'b0;
        end else begin
            step <= step_nxt;
            if (ir_ld)  ir <= MemData;
            if (pc_inc) pc <= pc + 1'b1;
            Err  <= err_nxt;
        end
    end

    assign MemAddr = pc;
    assign DIN     = MemData;
    assign Counter = step;
    assign IRout   = ir[DATA_W-1 -: 3];
    assign Busy    = (step != ST_FETCH);

    dec3to8 u_xdec (.sel(ir[5:3]), .onehot(Xreg));
    dec3to8 u_ydec (.sel(ir[2:0]), .onehot(Yreg));

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer with a synchronous instruction memory.
module tb_instr_sequencer;

    logic       clock = 1'b0;
    logic       Reset, Run, Done, Clear;
    logic [8:0] MemData;
    logic [7:0] MemAddr;
    logic [8:0] DIN;
    logic [2:0] Counter, IRout;
    logic [7:0] Xreg, Yreg;
    logic       Busy, Err;

    logic [8:0] mem [256];

    always #5 clock = ~clock;
    always @(posedge clock) MemData <= mem[MemAddr];

    instr_sequencer dut (
        .clock(clock), .Reset(Reset), .Run(Run), .Done(Done), .Clear(Clear),
        .MemData(MemData), .MemAddr(MemAddr), .DIN(DIN), .Counter(Counter),
        .IRout(IRout), .Xreg(Xreg), .Yreg(Yreg), .Busy(Busy), .Err(Err)
    );

    typedef struct {
        int         tid;
        logic [2:0] cnt;
        logic [7:0] addr;
        logic       err;
        bit         chk_ir;
        logic [2:0] op;
        logic [7:0] x;
        logic [7:0] y;
        bit         chk_din;
        logic [8:0] din;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0;
    int   n_chk2 = 0, n_fail2 = 0;

    task automatic chk(input int tid, input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL t%0d %s: got %h required %h at %0t", tid, nm, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tid, "counter", 32'(Counter), 32'(e.cnt));
            chk(e.tid, "memaddr", 32'(MemAddr), 32'(e.addr));
            chk(e.tid, "err",     32'(Err),     32'(e.err));
            chk(e.tid, "busy",    32'(Busy),    32'(e.cnt != 3'b000));
            if (e.chk_ir) begin
                chk(e.tid, "irout", 32'(IRout), 32'(e.op));
                chk(e.tid, "xreg",  32'(Xreg),  32'(e.x));
                chk(e.tid, "yreg",  32'(Yreg),  32'(e.y));
            end
            if (e.chk_din) chk(e.tid, "din", 32'(DIN), 32'(e.din));
        end
    end

    task automatic push(input int tid, input logic [2:0] cnt, input logic [7:0] addr, input logic err,
                        input bit chk_ir, input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        input bit chk_din, input logic [8:0] din);
        exp_t e;
        e.tid = tid; e.cnt = cnt; e.addr = addr; e.err = err;
        e.chk_ir = chk_ir; e.op = op; e.x = x; e.y = y;
        e.chk_din = chk_din; e.din = din;
        q.push_back(e);
    endtask

    task automatic ps(input int tid, input logic [2:0] cnt, input logic [7:0] addr, input logic err);
        push(tid, cnt, addr, err, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 9'd0);
    endtask

    task automatic pi(input int tid, input logic [2:0] cnt, input logic [7:0] addr, input logic err,
                      input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        push(tid, cnt, addr, err, 1'b1, op, x, y, 1'b0, 9'd0);
    endtask

    task automatic tick(input logic r, input logic d, input logic c);
        Run = r; Done = d; Clear = c;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int tid);
        Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Run   = 1'($urandom_range(0, 1));
            Done  = 1'($urandom_range(0, 1));
            Clear = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            pi(tid, 3'b000, 8'h00, 1'b0, 3'b000, 8'h01, 8'h01);
        end
        Reset = 1'b0;
        Run = 1'b0; Done = 1'b0; Clear = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; Done = 1'b0; Clear = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 9'h000;

        // 1/2: mv R1,R2; Done during 001/010 must be ignored
        mem[0] = 9'b110_001_010;
        do_reset(1);
        tick(1, 1, 0); pi(2, 3'b001, 8'h00, 0, 3'b000, 8'h01, 8'h01);
        tick(1, 1, 0); pi(2, 3'b010, 8'h01, 0, 3'b110, 8'h02, 8'h04);
        tick(1, 0, 0); pi(2, 3'b011, 8'h01, 0, 3'b110, 8'h02, 8'h04);
        tick(1, 1, 0); ps(2, 3'b000, 8'h01, 0);
        tick(0, 0, 0); ps(2, 3'b000, 8'h01, 0);

        // 3: mvi R3 with immediate 15A, then mv R0,R1 fetched from address 2
        mem[0] = 9'b111_011_000; mem[1] = 9'h15A; mem[2] = 9'b110_000_001;
        do_reset(3);
        tick(1, 0, 0); ps(3, 3'b001, 8'h00, 0);
        tick(1, 0, 0); pi(3, 3'b010, 8'h01, 0, 3'b111, 8'h08, 8'h01);
        tick(1, 0, 0); push(3, 3'b011, 8'h01, 0, 1, 3'b111, 8'h08, 8'h01, 1, 9'h15A);
        tick(1, 1, 0); ps(3, 3'b000, 8'h02, 0);
        tick(1, 0, 0); ps(3, 3'b001, 8'h02, 0);
        tick(1, 0, 0); pi(3, 3'b010, 8'h03, 0, 3'b110, 8'h01, 8'h02);
        tick(1, 1, 0); ps(3, 3'b011, 8'h03, 0);
        tick(0, 1, 0); ps(3, 3'b000, 8'h03, 0);
        tick(0, 0, 0); ps(3, 3'b000, 8'h03, 0);

        // 4: add R0,R1 without Done -> Err pulse; then add R2,R3 retired at 101
        mem[0] = 9'b000_000_001; mem[1] = 9'b000_010_011;
        do_reset(4);
        tick(1, 0, 0); ps(4, 3'b001, 8'h00, 0);
        tick(1, 0, 0); pi(4, 3'b010, 8'h01, 0, 3'b000, 8'h01, 8'h02);
        tick(1, 0, 0); ps(4, 3'b011, 8'h01, 0);
        tick(1, 0, 0); ps(4, 3'b100, 8'h01, 0);
        tick(1, 0, 0); ps(4, 3'b101, 8'h01, 0);
        tick(0, 0, 0); ps(4, 3'b000, 8'h01, 1);
        tick(0, 0, 0); ps(4, 3'b000, 8'h01, 0);
        tick(1, 0, 0); ps(4, 3'b001, 8'h01, 0);
        tick(1, 0, 0); pi(4, 3'b010, 8'h02, 0, 3'b000, 8'h04, 8'h08);
        tick(1, 0, 0); ps(4, 3'b011, 8'h02, 0);
        tick(1, 0, 0); ps(4, 3'b100, 8'h02, 0);
        tick(1, 0, 0); ps(4, 3'b101, 8'h02, 0);
        tick(0, 1, 0); ps(4, 3'b000, 8'h02, 0);

        // 5: Clear in 001 keeps PC/IR; Clear+Done in 011 of an mvi suppresses its increment
        mem[0] = 9'b110_001_010; mem[1] = 9'b111_000_101; mem[2] = 9'h0AA;
        do_reset(5);
        tick(1, 0, 0); ps(5, 3'b001, 8'h00, 0);
        tick(1, 0, 0); pi(5, 3'b010, 8'h01, 0, 3'b110, 8'h02, 8'h04);
        tick(1, 0, 0); ps(5, 3'b011, 8'h01, 0);
        tick(1, 1, 0); ps(5, 3'b000, 8'h01, 0);
        tick(1, 0, 0); pi(5, 3'b001, 8'h01, 0, 3'b110, 8'h02, 8'h04);
        tick(1, 0, 1); pi(5, 3'b000, 8'h01, 0, 3'b110, 8'h02, 8'h04);
        tick(0, 0, 0); pi(5, 3'b000, 8'h01, 0, 3'b110, 8'h02, 8'h04);
        tick(1, 0, 0); ps(5, 3'b001, 8'h01, 0);
        tick(1, 0, 0); pi(5, 3'b010, 8'h02, 0, 3'b111, 8'h01, 8'h20);
        tick(1, 0, 0); ps(5, 3'b011, 8'h02, 0);
        tick(1, 1, 1); pi(5, 3'b000, 8'h02, 0, 3'b111, 8'h01, 8'h20);
        tick(0, 0, 0); ps(5, 3'b000, 8'h02, 0);

        // 6: walk PC to FF with mv instructions, then wrap on the next fetch
        for (int i = 0; i < 256; i++) mem[i] = 9'b110_000_000;
        mem[255] = 9'b110_000_001;
        do_reset(6);
        for (int i = 0; i < 255; i++) begin
            tick(1, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(1, 1, 0);
        end
        ps(6, 3'b000, 8'hFF, 0);
        tick(1, 0, 0); pi(6, 3'b001, 8'hFF, 0, 3'b110, 8'h01, 8'h01);
        tick(1, 0, 0); pi(6, 3'b010, 8'h00, 0, 3'b110, 8'h01, 8'h02);
        tick(1, 0, 0); ps(6, 3'b011, 8'h00, 0);
        tick(0, 1, 0); ps(6, 3'b000, 8'h00, 0);
        tick(0, 0, 0); ps(6, 3'b000, 8'h00, 0);
        tick(0, 0, 0); ps(6, 3'b000, 8'h00, 0);

        repeat (3) @(posedge clock);
        n_chk2++;
        if (q.size() != 0) begin
            n_fail2++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk + n_chk2, n_fail + n_fail2);
        $finish;
    end

endmodule
